// File: rtl/digit_grid_locator_pkg.sv
// Shared constants and compile-time geometry helpers for the digit tile grid.
package digit_grid_locator_pkg;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;

   // Never returns 0, so one-tile grids still get a usable index port.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int left_edge(input int c, input int x0, input int pitch,
                                    input int group, input int gap);
      return x0 + c * pitch + (c / group) * gap;
   endfunction

   function automatic int top_edge(input int r, input int y0, input int pitch);
      return y0 + r * pitch;
   endfunction

endpackage

// File: rtl/digit_grid_locator_if.sv
// Scan-coordinate request and tile-result bundle between the timing generator and renderer.
interface digit_grid_locator_if #(
   parameter int COLS = 6,
   parameter int ROWS = 2,
   parameter int CW   = 10
);
   localparam int N  = ROWS * COLS;
   localparam int IW = digit_grid_locator_pkg::idx_w(N);

   logic           frame_start;
   logic           load_req;
   logic [4*N-1:0] numbers_concat;
   logic           sel_en;
   logic [IW-1:0]  sel_idx;
   logic [CW-1:0]  sx;
   logic [CW-1:0]  sy;

   logic [3:0]     number;
   logic [CW-1:0]  sx_offset;
   logic [CW-1:0]  sy_offset;
   logic           in_tile;
   logic [IW-1:0]  tile_idx;
   logic           highlight;

   modport master (
      output frame_start, load_req, numbers_concat, sel_en, sel_idx, sx, sy,
      input  number, sx_offset, sy_offset, in_tile, tile_idx, highlight
   );

   modport slave (
      input  frame_start, load_req, numbers_concat, sel_en, sel_idx, sx, sy,
      output number, sx_offset, sy_offset, in_tile, tile_idx, highlight
   );

endinterface

// File: rtl/digit_grid_locator_axis_locator.sv
// One-axis tile finder: which tile span (if any) holds the coordinate, and how far into it.
module digit_grid_locator_axis_locator
   import digit_grid_locator_pkg::*;
#(
   parameter int CW     = 10,
   parameter int N      = 6,
   parameter int ORIGIN = 20,
   parameter int PITCH  = 100,
   parameter int SIZE   = 80,
   parameter int GROUP  = 3,
   parameter int GAP    = 20,
   parameter int IW     = 4
) (
   input  logic [CW-1:0] coord,
   output logic          hit,
   output logic [IW-1:0] index,
   output logic [CW-1:0] offset
);

   // Spans never overlap because SIZE <= PITCH, so at most one iteration matches.
   always_comb begin
      hit    = 1'b0;
      index  = '0;
      offset = '0;
      for (int i = 0; i < N; i++) begin
         if (int'(coord) >= left_edge(i, ORIGIN, PITCH, GROUP, GAP) &&
             int'(coord) <  left_edge(i, ORIGIN, PITCH, GROUP, GAP) + SIZE) begin
            hit    = 1'b1;
            index  = IW'(i);
            offset = CW'(int'(coord) - left_edge(i, ORIGIN, PITCH, GROUP, GAP));
         end
      end
   end

endmodule

// File: rtl/digit_grid_locator.sv
// Two-stage pixel-to-digit-tile locator with frame-synchronous digit buffer and blinking cursor.
module digit_grid_locator
   import digit_grid_locator_pkg::*;
#(
   parameter int COLS         = 6,
   parameter int ROWS         = 2,
   parameter int CW           = 10,
   parameter int X0           = 20,
   parameter int Y0           = 20,
   parameter int TILE_W       = 80,
   parameter int TILE_H       = 140,
   parameter int PITCH_X      = 100,
   parameter int PITCH_Y      = 180,
   parameter int GROUP        = 3,
   parameter int GROUP_GAP    = 20,
   parameter int BLINK_FRAMES = 30
) (
   input logic clk,
   input logic rst_n,
   digit_grid_locator_if.slave bus
);

   localparam int N  = ROWS * COLS;
   localparam int IW = idx_w(N);
   localparam int BW = idx_w(BLINK_FRAMES);

   logic [4*N-1:0] shadow_q, shadow_d, active_q, active_d;
   logic [BW-1:0]  frame_cnt_q, frame_cnt_d;
   logic           blink_q, blink_d;

   logic           x_hit, y_hit;
   logic [IW-1:0]  x_idx, y_idx;
   logic [CW-1:0]  x_off, y_off;

   logic           x_hit_q, y_hit_q;
   logic [IW-1:0]  col_q, row_q;
   logic [CW-1:0]  x_off_q, y_off_q;

   int             tile_int;
   logic [3:0]     number_q, number_d;
   logic [CW-1:0]  sx_offset_q, sx_offset_d, sy_offset_q, sy_offset_d;
   logic           in_tile_q, in_tile_d;
   logic [IW-1:0]  tile_idx_q, tile_idx_d;
   logic           highlight_q, highlight_d;

   digit_grid_locator_axis_locator #(
      .CW(CW), .N(COLS), .ORIGIN(X0), .PITCH(PITCH_X), .SIZE(TILE_W),
      .GROUP(GROUP), .GAP(GROUP_GAP), .IW(IW)
   ) u_x_axis (
      .coord(bus.sx), .hit(x_hit), .index(x_idx), .offset(x_off)
   );

   // Rows have no grouping: one group spanning every row, zero gap.
   digit_grid_locator_axis_locator #(
      .CW(CW), .N(ROWS), .ORIGIN(Y0), .PITCH(PITCH_Y), .SIZE(TILE_H),
      .GROUP(ROWS), .GAP(0), .IW(IW)
   ) u_y_axis (
      .coord(bus.sy), .hit(y_hit), .index(y_idx), .offset(y_off)
   );

   // Active copy is taken from the pre-edge shadow, so a coincident load lands one frame later.
   always_comb begin
      shadow_d    = bus.load_req    ? bus.numbers_concat : shadow_q;
      active_d    = bus.frame_start ? shadow_q           : active_q;
      frame_cnt_d = frame_cnt_q;
      blink_d     = blink_q;
      if (bus.frame_start) begin
         if (frame_cnt_q == BW'(BLINK_FRAMES - 1)) begin
            frame_cnt_d = '0;
            blink_d     = ~blink_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      tile_int    = int'(row_q) * COLS + int'(col_q);
      in_tile_d   = x_hit_q & y_hit_q;
      tile_idx_d  = in_tile_d ? IW'(tile_int) : '0;
      sx_offset_d = in_tile_d ? x_off_q : '0;
      sy_offset_d = in_tile_d ? y_off_q : '0;
      number_d    = DIGIT_BLANK;
      for (int t = 0; t < N; t++) begin
         if (in_tile_d && tile_int == t) number_d = active_q[4*(N-1-t) +: 4];
      end
      highlight_d = in_tile_d & bus.sel_en & (tile_idx_d == bus.sel_idx) & blink_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_q    <= '1;
         active_q    <= '1;
         frame_cnt_q <= '0;
         blink_q     <= 1'b1;
         x_hit_q     <= 1'b0;
         y_hit_q     <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         x_off_q     <= '0;
         y_off_q     <= '0;
         number_q    <= DIGIT_BLANK;
         sx_offset_q <= '0;
         sy_offset_q <= '0;
         in_tile_q   <= 1'b0;
         tile_idx_q  <= '0;
         highlight_q <= 1'b0;
      end else begin
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         frame_cnt_q <= frame_cnt_d;
         blink_q     <= blink_d;
         x_hit_q     <= x_hit;
         y_hit_q     <= y_hit;
         col_q       <= x_idx;
         row_q       <= y_idx;
         x_off_q     <= x_off;
         y_off_q     <= y_off;
         number_q    <= number_d;
         sx_offset_q <= sx_offset_d;
         sy_offset_q <= sy_offset_d;
         in_tile_q   <= in_tile_d;
         tile_idx_q  <= tile_idx_d;
         highlight_q <= highlight_d;
      end
   end

   assign bus.number    = number_q;
   assign bus.sx_offset = sx_offset_q;
   assign bus.sy_offset = sy_offset_q;
   assign bus.in_tile   = in_tile_q;
   assign bus.tile_idx  = tile_idx_q;
   assign bus.highlight = highlight_q;

endmodule

// File: tb/tb_digit_grid_locator.sv
// Bench for digit_grid_locator: directed geometry/buffer/blink cases plus random traffic vs. a reference model.
module tb_digit_grid_locator;

   localparam int COLS = 6, ROWS = 2, CW = 10, N = 12, IW = 4, BLINK = 2;
   localparam int X0 = 20, Y0 = 20, TILE_W = 80, TILE_H = 140;
   localparam int PITCH_X = 100, PITCH_Y = 180, GROUP = 3, GROUP_GAP = 20;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   digit_grid_locator_if #(.COLS(COLS), .ROWS(ROWS), .CW(CW)) bus ();

   digit_grid_locator #(
      .COLS(COLS), .ROWS(ROWS), .CW(CW), .X0(X0), .Y0(Y0),
      .TILE_W(TILE_W), .TILE_H(TILE_H), .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y),
      .GROUP(GROUP), .GROUP_GAP(GROUP_GAP), .BLINK_FRAMES(BLINK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference state: digit buffers, frame pulses since reset, and the pixel sitting in stage 1.
   logic [4*N-1:0] m_shadow, m_active;
   int             m_pulses;
   bit             s1_valid;
   int             s1_x, s1_y;
   logic [3:0]     e_number;
   int             e_xo, e_yo, e_idx;
   bit             e_in, e_hl;
   bit             exp_hl[6] = '{1, 1, 0, 0, 1, 1};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Geometry from the group/pitch arithmetic: group index, then column inside group.
   function automatic bit locate(input int x, input int y, output int idx, output int xo, output int yo);
      int rx, ry, gw, r, ci, c, row;
      idx = 0; xo = 0; yo = 0;
      rx = x - X0;
      ry = y - Y0;
      if (rx < 0 || ry < 0) return 1'b0;
      gw  = GROUP * PITCH_X + GROUP_GAP;
      r   = rx % gw;
      ci  = r / PITCH_X;
      c   = (rx / gw) * GROUP + ci;
      row = ry / PITCH_Y;
      if (ci >= GROUP || r % PITCH_X >= TILE_W || c >= COLS) return 1'b0;
      if (row >= ROWS || ry % PITCH_Y >= TILE_H) return 1'b0;
      idx = row * COLS + c;
      xo  = r % PITCH_X;
      yo  = ry % PITCH_Y;
      return 1'b1;
   endfunction

   // Advance one clock: predict from pre-edge inputs, then compare all outputs after the edge.
   task automatic cycle();
      int idx, xo, yo;
      bit hit, phase;
      if (!rst_n) begin
         m_shadow = '1; m_active = '1; m_pulses = 0; s1_valid = 1'b0;
         e_number = 4'hF; e_xo = 0; e_yo = 0; e_in = 1'b0; e_idx = 0; e_hl = 1'b0;
      end else begin
         hit      = locate(s1_x, s1_y, idx, xo, yo) && s1_valid;
         phase    = ((m_pulses / BLINK) % 2) == 0;
         e_in     = hit;
         e_idx    = hit ? idx : 0;
         e_xo     = hit ? xo : 0;
         e_yo     = hit ? yo : 0;
         e_number = hit ? m_active[4*(N-1-idx) +: 4] : 4'hF;
         e_hl     = hit && bus.sel_en && (idx == int'(bus.sel_idx)) && phase;
         s1_valid = 1'b1;
         s1_x     = int'(bus.sx);
         s1_y     = int'(bus.sy);
         if (bus.frame_start) begin
            m_active = m_shadow;
            m_pulses++;
         end
         if (bus.load_req) m_shadow = bus.numbers_concat;
      end
      @(posedge clk);
      #1;
      check("number",    bus.number,    e_number);
      check("sx_offset", bus.sx_offset, e_xo);
      check("sy_offset", bus.sy_offset, e_yo);
      check("in_tile",   bus.in_tile,   e_in);
      check("tile_idx",  bus.tile_idx,  e_idx);
      check("highlight", bus.highlight, e_hl);
   endtask

   task automatic pix(input int x, input int y);
      bus.sx = CW'(x);
      bus.sy = CW'(y);
      cycle();
      cycle();
   endtask

   task automatic dchk(input string tag, input int num, input int in, input int idx,
                       input int xo, input int yo);
      check({tag, ".number"},   bus.number,    num);
      check({tag, ".in_tile"},  bus.in_tile,   in);
      check({tag, ".tile_idx"}, bus.tile_idx,  idx);
      check({tag, ".sx_off"},   bus.sx_offset, xo);
      check({tag, ".sy_off"},   bus.sy_offset, yo);
   endtask

   task automatic pulse_frame();
      bus.frame_start = 1'b1;
      cycle();
      bus.frame_start = 1'b0;
   endtask

   task automatic load(input logic [4*N-1:0] v);
      bus.numbers_concat = v;
      bus.load_req       = 1'b1;
      cycle();
      bus.load_req       = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.frame_start = 1'b0; bus.load_req = 1'b0; bus.numbers_concat = '0;
      bus.sel_en = 1'b0; bus.sel_idx = '0; bus.sx = '0; bus.sy = '0;
      cycle();
      cycle();
      dchk("reset", 15, 0, 0, 0, 0);
      check("reset.highlight", bus.highlight, 0);
      rst_n = 1'b1;

      pulse_frame();
      pix(50, 50);   dchk("blank_tile0", 15, 1, 0, 30, 30);

      load(48'h0123456789AB);
      pulse_frame();
      pix(340, 20);  dchk("tile3_corner", 3, 1, 3, 0, 0);
      pix(300, 20);  dchk("between_300", 15, 0, 0, 0, 0);
      pix(99, 159);  dchk("tile0_last", 0, 1, 0, 79, 139);
      pix(100, 159); dchk("x_past_edge", 15, 0, 0, 0, 0);
      pix(99, 160);  dchk("y_past_edge", 15, 0, 0, 0, 0);
      pix(619, 339); dchk("tile11_last", 11, 1, 11, 79, 139);
      pix(320, 20);  dchk("group_gap", 15, 0, 0, 0, 0);

      load(48'h777777777777);
      pix(140, 60);  dchk("no_tear_old", 1, 1, 1, 20, 40);
      pulse_frame();
      pix(140, 60);  dchk("no_tear_new", 7, 1, 1, 20, 40);
      bus.numbers_concat = 48'h0123456789AB;
      bus.load_req = 1'b1; bus.frame_start = 1'b1;
      cycle();
      bus.load_req = 1'b0; bus.frame_start = 1'b0;
      pix(140, 60);  dchk("coincident_hold", 7, 1, 1, 20, 40);
      pulse_frame();
      pix(140, 60);  dchk("coincident_next", 1, 1, 1, 20, 40);

      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      bus.sel_idx = 4'd4;
      for (int f = 0; f < 6; f++) begin
         bus.sel_en = 1'b1;
         pix(460, 50);
         check($sformatf("blink_f%0d", f), bus.highlight, exp_hl[f]);
         pix(560, 50);
         check($sformatf("blink_tile5_f%0d", f), bus.highlight, 0);
         bus.sel_en = 1'b0;
         pix(460, 50);
         check($sformatf("blink_seloff_f%0d", f), bus.highlight, 0);
         pulse_frame();
      end

      load(48'h0123456789AB);
      pulse_frame();
      pix(140, 60);  dchk("pre_reset", 1, 1, 1, 20, 40);
      rst_n = 1'b0;
      cycle();
      dchk("mid_reset", 15, 0, 0, 0, 0);
      rst_n = 1'b1;
      pix(140, 60);  dchk("post_reset_blank", 15, 1, 1, 20, 40);
      load(48'h0123456789AB);
      pulse_frame();
      pix(140, 60);  dchk("post_reset_reload", 1, 1, 1, 20, 40);

      for (int i = 0; i < 800; i++) begin
         rst_n              = ($urandom_range(0, 299) != 0);
         bus.frame_start    = ($urandom_range(0, 39) == 0);
         bus.load_req       = ($urandom_range(0, 19) == 0);
         bus.numbers_concat = 48'({$urandom(), $urandom()});
         bus.sel_en         = ($urandom_range(0, 3) != 0);
         bus.sel_idx        = IW'($urandom_range(0, 15));
         bus.sx             = CW'($urandom_range(0, 700));
         bus.sy             = CW'($urandom_range(0, 420));
         cycle();
      end
      rst_n = 1'b1;
      bus.frame_start = 1'b0;
      bus.load_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
